// File: rtl/fetch_queue.sv
// fetch_queue: PC-driven instruction fetch into a small FIFO, with halt-opcode stop and redirect flush.
module fetch_queue #(
  parameter int ADDRBITWIDTH = 16,
  parameter int INSTBITWIDTH = 16,
  parameter int DEPTH = 4,
  parameter logic [ADDRBITWIDTH-1:0] RESETVECTOR = '0,
  parameter logic [INSTBITWIDTH-1:0] HALTOPCODE = 16'hFFFF
) (
  input  logic                         clk,
  input  logic                         sync_rst,
  input  logic                         clk_en,
  input  logic                         SystemEn,
  input  logic                         Redirect_Valid,
  input  logic [ADDRBITWIDTH-1:0]      Redirect_Addr,
  output logic [ADDRBITWIDTH-1:0]      InstructionAddress,
  input  logic [INSTBITWIDTH-1:0]      InstructionIn,
  output logic                         Inst_Valid,
  output logic [INSTBITWIDTH-1:0]      Inst_Data,
  output logic [ADDRBITWIDTH-1:0]      Inst_Addr,
  input  logic                         Inst_Ready,
  output logic [$clog2(DEPTH+1)-1:0]   Occupancy,
  output logic                         HaltOut
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HALT = 1'b1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);
  logic [ADDRBITWIDTH-1:0]              r_pc;
  logic [PW-1:0]                        r_head, r_tail;
  logic [OW-1:0]                        r_occ;
  logic [0:0]                           r_state;
  logic [ADDRBITWIDTH+INSTBITWIDTH-1:0] r_mem [DEPTH];
  logic                                 w_deq, w_fetch;
  assign w_deq = clk_en & Inst_Valid & Inst_Ready & sync_rst;
  // A dequeue frees a slot in the same cycle, so a full queue can still fetch.
  assign w_fetch = clk_en & sync_rst & SystemEn & ~Redirect_Valid & (r_state == FETCH)
                 & ((r_occ != FULL) | w_deq);
  assign InstructionAddress = r_pc;
  assign Inst_Valid = r_occ != '0;
  assign {Inst_Addr, Inst_Data} = r_mem[r_head];
  assign Occupancy = r_occ;
  assign HaltOut = (r_state == HALT) & (r_occ == '0);
  always_ff @(posedge clk)
    if (w_fetch) r_mem[r_tail] <= {r_pc, InstructionIn};
  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      r_pc    <= RESETVECTOR;
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= '0;
      r_state <= FETCH;
    end else if (clk_en) begin
      if (Redirect_Valid) begin
        r_pc    <= Redirect_Addr;
        r_head  <= '0;
        r_tail  <= '0;
        r_occ   <= '0;
        r_state <= FETCH;
      end else begin
        if (w_fetch) begin
          r_tail <= r_tail + 1'b1;
          r_pc   <= r_pc + 1'b1;
          if (InstructionIn == HALTOPCODE) r_state <= HALT;
        end
        if (w_deq) r_head <= r_head + 1'b1;
        r_occ <= r_occ + OW'(w_fetch) - OW'(w_deq);
      end
    end
  end
endmodule
